axis_power3_checker: RTL

AXI-Stream slave that sits at the receiving end of the power-of-3 generator stream. It buffers incoming beats in a small FIFO and drains them into a checker stage. The checker compares each word against an internally regenerated power-of-3 sequence. It reports the word count, the error count, a sticky error flag and a capture of the first mismatch, for lab self-checking and for on-board debug.

---
 rtl/axis_power3_checker_if.sv | 26 ++
 rtl/axis_power3_checker.sv | 121 ++++++++++++
 2 files changed

// File: rtl/axis_power3_checker_if.sv
// AXI-Stream beat bundle between the power-of-3 generator (master) and the checker (slave).
interface axis_power3_checker_if #(
  parameter int DATA_SIZE = 32
);
  logic [DATA_SIZE-1:0]   s00_axis_tdata;
  logic [DATA_SIZE/8-1:0] s00_axis_tstrb;
  logic                   s00_axis_tvalid;
  logic                   s00_axis_tlast;
  logic                   s00_axis_tready;

  modport master (
    output s00_axis_tdata,
    output s00_axis_tstrb,
    output s00_axis_tvalid,
    output s00_axis_tlast,
    input  s00_axis_tready
  );

  modport slave (
    input  s00_axis_tdata,
    input  s00_axis_tstrb,
    input  s00_axis_tvalid,
    input  s00_axis_tlast,
    output s00_axis_tready
  );
endinterface

// File: rtl/axis_power3_checker.sv
// Buffers an AXI-Stream of powers of 3 in a small FIFO and checks each drained word
// against a regenerated sequence, keeping counters and a first-mismatch capture.
module axis_power3_checker #(
  parameter int DATA_SIZE  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          s00_axis_aclk,
  input  logic                          s00_axis_areset,
  axis_power3_checker_if.slave          s00_axis,
  input  logic                          check_enable,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          word_count,
  output logic [CNT_WIDTH-1:0]          error_count,
  output logic                          error_flag,
  output logic [DATA_SIZE-1:0]          first_err_data,
  output logic [DATA_SIZE-1:0]          first_err_expected
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAIL} checkState_t;

  logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wrPtr;
  logic [AW-1:0]        r_rdPtr;
  logic [LW-1:0]        r_level;

  checkState_t          r_state;
  logic [DATA_SIZE-1:0] r_expected;
  logic [CNT_WIDTH-1:0] r_wordCount;
  logic [CNT_WIDTH-1:0] r_errorCount;
  logic                 r_errorFlag;
  logic [DATA_SIZE-1:0] r_firstErrData;
  logic [DATA_SIZE-1:0] r_firstErrExpected;

  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_match;
  logic [DATA_SIZE-1:0] w_head;
  logic [DATA_SIZE-1:0] w_nextExpected;
  logic                 w_unused;

  // tready comes only from the registered level, so a pop on a full FIFO cannot admit a push.
  assign w_ready        = (r_level < FULL_LEVEL);
  assign w_push         = s00_axis.s00_axis_tvalid && w_ready;
  assign w_pop          = check_enable && (r_level != '0);
  assign w_head         = r_mem[r_rdPtr];
  assign w_match        = (w_head == r_expected);
  assign w_nextExpected = r_expected + {r_expected[DATA_SIZE-2:0], 1'b0};
  assign w_unused       = ^{s00_axis.s00_axis_tstrb, s00_axis.s00_axis_tlast};

  assign s00_axis.s00_axis_tready = w_ready;
  assign fifo_level               = r_level;
  assign word_count               = r_wordCount;
  assign error_count              = r_errorCount;
  assign error_flag               = r_errorFlag;
  assign first_err_data           = r_firstErrData;
  assign first_err_expected       = r_firstErrExpected;

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= s00_axis.s00_axis_tdata;
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // The expected value advances on every pop, so one bad word does not desynchronise the rest.
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_state            <= ST_IDLE;
      r_expected         <= DATA_SIZE'(3);
      r_wordCount        <= '0;
      r_errorCount       <= '0;
      r_errorFlag        <= 1'b0;
      r_firstErrData     <= '0;
      r_firstErrExpected <= '0;
    end else if (w_pop) begin
      r_expected <= w_nextExpected;
      if (r_wordCount != '1) begin
        r_wordCount <= r_wordCount + 1'b1;
      end
      if (!w_match) begin
        if (r_errorCount != '1) begin
          r_errorCount <= r_errorCount + 1'b1;
        end
        if (r_state != ST_FAIL) begin
          r_errorFlag        <= 1'b1;
          r_firstErrData     <= w_head;
          r_firstErrExpected <= r_expected;
        end
      end
      case (r_state)
        ST_IDLE: r_state <= w_match ? ST_RUN : ST_FAIL;
        ST_RUN:  r_state <= w_match ? ST_RUN : ST_FAIL;
        default: r_state <= ST_FAIL;
      endcase
    end
  end

endmodule
